// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline stage: valid/ready handshake, two-entry skid buffer (main M + skid S),
// flush, bubble masking of control fields and a saturating stall-cycle counter.
module ex_mem_stage_buf #(
  parameter int XLEN   = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_zero,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [XLEN-1:0]   in_branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_zero,
  output logic [RD_W-1:0]   out_rd,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [XLEN-1:0]   out_store_data,
  output logic [XLEN-1:0]   out_branch_target,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BEAT_W = CTRL_W + 1 + RD_W + 3 * XLEN;

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [BEAT_W-1:0] m_beat_q, m_beat_d;
  logic [BEAT_W-1:0] s_beat_q, s_beat_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [BEAT_W-1:0] in_beat_s;
  logic              in_fire_s, out_fire_s;

  logic [CTRL_W-1:0] m_ctrl_s;
  logic              m_zero_s;
  logic [RD_W-1:0]   m_rd_s;

  assign in_beat_s  = {in_ctrl, in_zero, in_rd, in_alu_result, in_store_data, in_branch_target};
  assign in_fire_s  = in_valid & in_ready_q;
  assign out_fire_s = m_valid_q & out_ready;

  // Next-state for storage, handshake ready and stall counter
  always_comb begin
    m_valid_d   = m_valid_q;
    s_valid_d   = s_valid_q;
    m_beat_d    = m_beat_q;
    s_beat_d    = s_beat_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      case ({s_valid_q, m_valid_q})
        2'b00: begin
          if (in_fire_s) begin
            m_valid_d = 1'b1;
            m_beat_d  = in_beat_s;
          end else begin
            m_valid_d = 1'b0;
          end
        end
        2'b01: begin
          if (in_fire_s && out_fire_s) begin
            m_beat_d = in_beat_s;
          end else if (out_fire_s) begin
            m_valid_d = 1'b0;
          end else if (in_fire_s) begin
            s_valid_d = 1'b1;
            s_beat_d  = in_beat_s;
          end else begin
            m_valid_d = 1'b1;
          end
        end
        2'b11: begin
          // Skid beat moves up; ready is low so no new beat can arrive here
          if (out_fire_s) begin
            m_beat_d  = s_beat_q;
            s_valid_d = 1'b0;
          end else begin
            s_valid_d = 1'b1;
          end
        end
        default: begin
          m_valid_d = 1'b0;
          s_valid_d = 1'b0;
        end
      endcase
    end

    in_ready_d = ~s_valid_d;

    if (m_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid_q   <= 1'b0;
      s_valid_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      m_beat_q    <= {BEAT_W{1'b0}};
      s_beat_q    <= {BEAT_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      m_valid_q   <= m_valid_d;
      s_valid_q   <= s_valid_d;
      in_ready_q  <= in_ready_d;
      m_beat_q    <= m_beat_d;
      s_beat_q    <= s_beat_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {m_ctrl_s, m_zero_s, m_rd_s, out_alu_result, out_store_data, out_branch_target} = m_beat_q;

  // Bubbles carry no control so they can never write the RF or memory
  assign out_valid = m_valid_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_s : {CTRL_W{1'b0}};
  assign out_zero  = m_valid_q & m_zero_s;
  assign out_rd    = m_valid_q ? m_rd_s : {RD_W{1'b0}};
  assign in_ready  = in_ready_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Directed bench for ex_mem_stage_buf (CNT_W=3 so counter saturation is reachable).
module tb_ex_mem_stage_buf;

  localparam int XLEN = 64;
  localparam int RD_W = 5;
  localparam int CTRL_W = 5;
  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid, in_zero, out_zero;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [RD_W-1:0]   in_rd, out_rd;
  logic [XLEN-1:0]   in_alu_result, in_store_data, in_branch_target;
  logic [XLEN-1:0]   out_alu_result, out_store_data, out_branch_target;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  ex_mem_stage_buf #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_zero(in_zero),
    .in_rd(in_rd), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_branch_target(in_branch_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_zero(out_zero),
    .out_rd(out_rd), .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_branch_target(out_branch_target), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] alu);
    in_valid = v;
    in_alu_result = alu;
    in_store_data = alu + 64'd100;
    in_branch_target = alu + 64'd200;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 64'd0);
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_ctrl = 5'b00000; in_zero = 1'b0; in_rd = 5'd0;
    drive(1'b1, 64'd99);

    // 1. reset held 3 cycles with in_valid=1
    step(); step(); step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_ctrl", {59'd0, out_ctrl}, 64'd0);
    check("rst_occ", {62'd0, occupancy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_stall", {61'd0, stall_cnt}, 64'd0);
    reset = 1'b1;
    drive(1'b0, 64'd0);
    step();
    check("rel_in_ready", {63'd0, in_ready}, 64'd1);
    check("rel_out_valid", {63'd0, out_valid}, 64'd0);

    // 2. streaming 1..8 with out_ready=1
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 64'(k));
      step();
      check("strm_valid", {63'd0, out_valid}, 64'd1);
      check("strm_data", out_alu_result, 64'(k));
      check("strm_occ", {62'd0, occupancy}, 64'd1);
    end
    check("strm_store", out_store_data, 64'd108);
    drive(1'b0, 64'd0);
    step();
    check("strm_drain", {63'd0, out_valid}, 64'd0);

    // 3. backpressure A,B,C
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 64'hA);
    step();
    check("bp_A_out", out_alu_result, 64'hA);
    out_ready = 1'b0;
    drive(1'b1, 64'hB);
    step();
    check("bp_occ2", {62'd0, occupancy}, 64'd2);
    check("bp_rdy0", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 64'hC);
    step(); step(); step();
    check("bp_hold_A", out_alu_result, 64'hA);
    check("bp_stall4", {61'd0, stall_cnt}, 64'd4);
    check("bp_occ2b", {62'd0, occupancy}, 64'd2);
    out_ready = 1'b1;
    step();
    check("bp_B_out", out_alu_result, 64'hB);
    check("bp_B_tgt", out_branch_target, 64'hB + 64'd200);
    check("bp_occ1", {62'd0, occupancy}, 64'd1);
    check("bp_rdy1", {63'd0, in_ready}, 64'd1);
    step();
    check("bp_C_out", out_alu_result, 64'hC);
    check("bp_C_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b0, 64'd0);
    step();
    check("bp_empty", {63'd0, out_valid}, 64'd0);
    check("bp_stall_keep", {61'd0, stall_cnt}, 64'd4);

    // 4. flush while FULL with concurrent input, then flush with accepted input
    do_reset();
    out_ready = 1'b0;
    in_ctrl = 5'b11111; in_rd = 5'd3;
    drive(1'b1, 64'h11);
    step();
    drive(1'b1, 64'h22);
    step();
    check("fl_full", {62'd0, occupancy}, 64'd2);
    flush = 1'b1;
    drive(1'b1, 64'h33);
    step();
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_occ", {62'd0, occupancy}, 64'd0);
    check("fl_ctrl", {59'd0, out_ctrl}, 64'd0);
    check("fl_rdy", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 64'h44);
    step();
    check("fl_drop_in", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 64'd0);
    step();
    check("fl_quiet", {63'd0, out_valid}, 64'd0);
    drive(1'b1, 64'h55);
    step();
    check("fl_next_beat", out_alu_result, 64'h55);
    drive(1'b0, 64'd0);
    step();

    // 5. bubble masking
    do_reset();
    out_ready = 1'b1;
    in_ctrl = 5'b01010; in_rd = 5'd7; in_zero = 1'b1;
    drive(1'b1, 64'h66);
    step();
    check("bm_ctrl_live", {59'd0, out_ctrl}, 64'h0A);
    check("bm_rd_live", {59'd0, out_rd}, 64'd7);
    check("bm_zero_live", {63'd0, out_zero}, 64'd1);
    drive(1'b0, 64'd0);
    step();
    check("bm_ctrl_mask", {59'd0, out_ctrl}, 64'd0);
    check("bm_rd_mask", {59'd0, out_rd}, 64'd0);
    check("bm_zero_mask", {63'd0, out_zero}, 64'd0);
    check("bm_alu_keep", out_alu_result, 64'h66);

    // 6. stall counter saturation at 7
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 64'h77);
    step();
    drive(1'b0, 64'd0);
    for (int n = 1; n <= 12; n++) begin
      step();
      check("sat_cnt", {61'd0, stall_cnt}, (n < 7) ? 64'(n) : 64'd7);
    end
    check("sat_hold_data", out_alu_result, 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
